// File: rtl/fifo_dcfifo_pkg.sv
// Shared sizing for the byte-in / word-out FIFO: widths, depth and derived
// pointer and count widths.
package fifo_dcfifo_pkg;

    localparam int unsigned WR_W     = 8;
    localparam int unsigned RD_W     = 2 * WR_W;
    localparam int unsigned WR_DEPTH = 256;
    localparam int unsigned BYTE_AW  = $clog2(WR_DEPTH);
    localparam int unsigned WORD_AW  = BYTE_AW - 1;
    localparam int unsigned CNT_W    = BYTE_AW + 1;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [BYTE_AW-1:0] byte_addr_t;
    typedef logic [WORD_AW-1:0] word_addr_t;

endpackage

// File: rtl/fifo_dcfifo_if.sv
// Write/read handshake and status bundle between a producer/consumer (master)
// and the FIFO (slave).
interface fifo_dcfifo_if;
    import fifo_dcfifo_pkg::*;

    logic               wr_req;
    logic [WR_W-1:0]    wr_data;
    logic               rd_req;
    logic [RD_W-1:0]    rd_data;
    logic               wr_full;
    logic               wr_empty;
    logic [CNT_W-1:0]   wr_usedw;
    logic               rd_full;
    logic               rd_empty;
    logic [CNT_W-2:0]   rd_usedw;

    modport master (
        output wr_req, wr_data, rd_req,
        input  rd_data, wr_full, wr_empty, wr_usedw, rd_full, rd_empty, rd_usedw
    );

    modport slave (
        input  wr_req, wr_data, rd_req,
        output rd_data, wr_full, wr_empty, wr_usedw, rd_full, rd_empty, rd_usedw
    );

endinterface

// File: rtl/fifo_dcfifo_ram.sv
// Byte-wide storage with a single write port and a registered read port that
// returns the even/odd byte pair of one word address.
module fifo_dcfifo_ram
    import fifo_dcfifo_pkg::*;
#(
    parameter int unsigned DW    = WR_W,
    parameter int unsigned RW    = RD_W,
    parameter int unsigned DEPTH = WR_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-2:0] i_rd_addr,
    output logic [RW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [RW-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Older (even) byte goes to the low half of the word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= {r_mem[{i_rd_addr, 1'b1}], r_mem[{i_rd_addr, 1'b0}]};
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_dcfifo.sv
// Single-clock FIFO taking one byte per write and delivering one two-byte word
// per read; every status output is decoded from one byte count.
module fifo_dcfifo #(
    parameter int unsigned WR_W     = fifo_dcfifo_pkg::WR_W,
    parameter int unsigned RD_W     = fifo_dcfifo_pkg::RD_W,
    parameter int unsigned WR_DEPTH = fifo_dcfifo_pkg::WR_DEPTH
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    fifo_dcfifo_if.slave  bus
);

    localparam int unsigned BYTE_AW = $clog2(WR_DEPTH);
    localparam int unsigned WORD_AW = BYTE_AW - 1;
    localparam int unsigned CNT_W   = BYTE_AW + 1;

    logic [CNT_W-1:0]   r_cnt;
    logic [BYTE_AW-1:0] r_wr_ptr;
    logic [WORD_AW-1:0] r_rd_ptr;

    logic               w_wr_full;
    logic               w_rd_empty;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [CNT_W-1:0]   w_cnt_nxt;

    assign w_wr_full  = (r_cnt == CNT_W'(WR_DEPTH));
    assign w_rd_empty = (r_cnt < CNT_W'(2));
    assign w_wr_acc   = bus.wr_req && !w_wr_full;
    assign w_rd_acc   = bus.rd_req && !w_rd_empty;

    // Net change is +1 per accepted byte and -2 per accepted word.
    assign w_cnt_nxt  = r_cnt + CNT_W'(w_wr_acc) - (CNT_W'(w_rd_acc) << 1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    fifo_dcfifo_ram #(
        .DW    (WR_W),
        .RW    (RD_W),
        .DEPTH (WR_DEPTH),
        .AW    (BYTE_AW)
    ) u_ram (
        .i_clk     (sys_clk),
        .i_rst     (sys_rst),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (bus.rd_data)
    );

    assign bus.wr_full  = w_wr_full;
    assign bus.wr_empty = (r_cnt == '0);
    assign bus.wr_usedw = r_cnt;
    assign bus.rd_full  = (r_cnt[CNT_W-1:1] == (CNT_W-1)'(WR_DEPTH / 2));
    assign bus.rd_empty = w_rd_empty;
    assign bus.rd_usedw = r_cnt[CNT_W-1:1];

endmodule

// File: tb/tb_fifo_dcfifo.sv
// Directed bench for fifo_dcfifo: a byte-queue model checked every cycle plus
// hand-computed expectations at the key points of each scenario.
module tb_fifo_dcfifo;

    logic sys_clk = 1'b0;
    logic sys_rst;

    always #5 sys_clk = ~sys_clk;

    fifo_dcfifo_if bus ();

    fifo_dcfifo dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  m_q[$];
    logic [15:0] m_rd = 16'h0000;
    bit          m_live = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Acceptance uses the stored byte count before this edge.
    function automatic void model_step(input logic rst, input logic wr, input logic [7:0] d,
                                       input logic rd);
        int n;
        if (rst) begin
            m_q.delete();
            m_rd = 16'h0000;
            m_live = 1'b1;
            return;
        end
        if (!m_live) return;
        n = m_q.size();
        if (rd && n >= 2) begin
            m_rd = {m_q[1], m_q[0]};
            void'(m_q.pop_front());
            void'(m_q.pop_front());
        end
        if (wr && n < 256) m_q.push_back(d);
    endfunction

    always @(posedge sys_clk) model_step(sys_rst, bus.wr_req, bus.wr_data, bus.rd_req);

    task automatic compare_all();
        int n;
        n = m_q.size();
        check("wr_usedw", 32'(bus.wr_usedw), n);
        check("wr_full", 32'(bus.wr_full), 32'(n == 256));
        check("wr_empty", 32'(bus.wr_empty), 32'(n == 0));
        check("rd_usedw", 32'(bus.rd_usedw), n / 2);
        check("rd_full", 32'(bus.rd_full), 32'(n / 2 == 128));
        check("rd_empty", 32'(bus.rd_empty), 32'(n < 2));
        check("rd_data", 32'(bus.rd_data), 32'(m_rd));
    endtask

    always @(negedge sys_clk) begin
        if (m_live) compare_all();
    end

    task automatic cyc(input logic wr, input logic [7:0] d, input logic rd);
        bus.wr_req  = wr;
        bus.wr_data = d;
        bus.rd_req  = rd;
        @(posedge sys_clk);
        #1;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
    endtask

    function automatic logic [15:0] pair(input logic [7:0] lo);
        logic [7:0] hi;
        hi = lo + 8'd1;
        return {hi, lo};
    endfunction

    logic [7:0]  wv;
    logic [7:0]  rv;
    logic [15:0] last_rd;

    initial begin
        sys_rst     = 1'b1;
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.wr_data = 8'h00;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h77, 1'b1);
        sys_rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        check("rst_wr_empty", 32'(bus.wr_empty), 1);
        check("rst_rd_empty", 32'(bus.rd_empty), 1);
        check("rst_wr_usedw", 32'(bus.wr_usedw), 0);
        check("rst_rd_usedw", 32'(bus.rd_usedw), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_model_cnt", m_q.size(), 0);

        // Fill 0..255, then one ignored write.
        for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 1'b0);
        check("fill_wr_usedw", 32'(bus.wr_usedw), 256);
        check("fill_wr_full", 32'(bus.wr_full), 1);
        check("fill_rd_full", 32'(bus.rd_full), 1);
        check("fill_rd_usedw", 32'(bus.rd_usedw), 128);
        check("fill_model_cnt", m_q.size(), 256);
        cyc(1'b1, 8'h55, 1'b0);
        check("over_wr_usedw", 32'(bus.wr_usedw), 256);

        for (int i = 0; i < 128; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            check("drain_data", 32'(bus.rd_data), 32'(pair(8'(2 * i))));
        end
        check("drain_rd_empty", 32'(bus.rd_empty), 1);
        check("drain_wr_empty", 32'(bus.wr_empty), 1);
        cyc(1'b0, 8'h00, 1'b1);
        check("under_rd_data", 32'(bus.rd_data), 32'h0000fffe);
        check("model_rd_pin", 32'(m_rd), 32'h0000fffe);

        // Odd byte waits for its partner.
        cyc(1'b1, 8'hAA, 1'b0);
        check("odd_wr_usedw", 32'(bus.wr_usedw), 1);
        check("odd_rd_usedw", 32'(bus.rd_usedw), 0);
        check("odd_rd_empty", 32'(bus.rd_empty), 1);
        cyc(1'b0, 8'h00, 1'b1);
        check("odd_rd_hold", 32'(bus.rd_data), 32'h0000fffe);
        check("odd_cnt_hold", 32'(bus.wr_usedw), 1);
        cyc(1'b1, 8'hBB, 1'b0);
        check("pair_rd_empty", 32'(bus.rd_empty), 0);
        cyc(1'b0, 8'h00, 1'b1);
        check("pair_rd_data", 32'(bus.rd_data), 32'h0000bbaa);

        // Pointer wrap with pointers starting mid-array.
        wv = 8'h10;
        rv = 8'h10;
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, wv, 1'b0);
            wv = wv + 8'd1;
        end
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            check("wrap_rd_a", 32'(bus.rd_data), 32'(pair(rv)));
            rv = rv + 8'd2;
        end
        for (int i = 0; i < 128; i++) begin
            cyc(1'b1, wv, 1'b0);
            wv = wv + 8'd1;
        end
        check("wrap_wr_usedw", 32'(bus.wr_usedw), 256);
        for (int i = 0; i < 128; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            check("wrap_rd_b", 32'(bus.rd_data), 32'(pair(rv)));
            rv = rv + 8'd2;
        end
        check("wrap_wr_empty", 32'(bus.wr_empty), 1);

        // Simultaneous write and read at cnt=10, 256 and 1.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, wv, 1'b0);
            wv = wv + 8'd1;
        end
        cyc(1'b1, wv, 1'b1);
        wv = wv + 8'd1;
        check("sim10_cnt", 32'(bus.wr_usedw), 9);
        check("sim10_data", 32'(bus.rd_data), 32'(pair(rv)));
        rv = rv + 8'd2;
        for (int i = 0; i < 247; i++) begin
            cyc(1'b1, wv, 1'b0);
            wv = wv + 8'd1;
        end
        check("sim256_full", 32'(bus.wr_full), 1);
        cyc(1'b1, 8'hEE, 1'b1);
        check("sim256_cnt", 32'(bus.wr_usedw), 254);
        check("sim256_data", 32'(bus.rd_data), 32'(pair(rv)));
        rv = rv + 8'd2;
        for (int i = 0; i < 127; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            rv = rv + 8'd2;
        end
        last_rd = pair(rv - 8'd2);
        check("sim_drained", 32'(bus.wr_usedw), 0);
        cyc(1'b1, 8'h3C, 1'b0);
        cyc(1'b1, 8'h5A, 1'b1);
        check("sim1_cnt", 32'(bus.wr_usedw), 2);
        check("sim1_rd_hold", 32'(bus.rd_data), 32'(last_rd));

        // Reset mid-stream beats concurrent requests.
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b1);
        sys_rst = 1'b1;
        cyc(1'b1, 8'h03, 1'b1);
        sys_rst = 1'b0;
        check("mid_rst_wr_empty", 32'(bus.wr_empty), 1);
        check("mid_rst_rd_empty", 32'(bus.rd_empty), 1);
        check("mid_rst_wr_full", 32'(bus.wr_full), 0);
        check("mid_rst_rd_full", 32'(bus.rd_full), 0);
        check("mid_rst_wr_usedw", 32'(bus.wr_usedw), 0);
        check("mid_rst_rd_usedw", 32'(bus.rd_usedw), 0);
        check("mid_rst_rd_data", 32'(bus.rd_data), 0);
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        check("post_rst_data", 32'(bus.rd_data), 32'h00002211);
        cyc(1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_dcfifo.md
FIFO_DCFIFO -- requirements
Module: fifo_dcfifo

Interface
REQ-001 Parameters SHALL be: WR_W default 8, write word width; RD_W default 16, read word width (2*WR_W); WR_DEPTH default 256, capacity in write words.
REQ-002 sys_clk  input  1  single clock for all logic; one clock, no clock-domain crossing.
REQ-003 sys_rst  input  1  reset, synchronous, active-high.
REQ-004 wr_req   input  1  write request; one byte per cycle.
REQ-005 wr_data  input  8  write byte.
REQ-006 rd_req   input  1  read request; one 16-bit word per cycle.
REQ-007 rd_data  output 16 read word, registered.
REQ-008 wr_full  output 1  256 bytes stored.
REQ-009 wr_empty output 1  0 bytes stored.
REQ-010 wr_usedw output 9  stored byte count, 0..256.
REQ-011 rd_full  output 1  128 words stored.
REQ-012 rd_empty output 1  fewer than 2 bytes stored, so no complete word.
REQ-013 rd_usedw output 8  complete words stored (byte count >> 1), 0..128.

Function
REQ-014 Internal byte count `cnt` (9 bits, 0..256) SHALL be the single source of truth; all status outputs SHALL be combinational decodes of cnt.
REQ-015 Write SHALL be accepted when wr_req=1 and wr_full=0; the byte is stored at the write pointer, and the 8-bit pointer wraps 255->0.
REQ-016 Write while wr_full=1 SHALL be ignored; no state changes.
REQ-017 Read SHALL be accepted when rd_req=1 and rd_empty=0; it removes the two oldest bytes, and the 7-bit word pointer wraps 127->0.
REQ-018 Read while rd_empty=1 SHALL be ignored; rd_data holds.
REQ-019 Packing: rd_data[7:0] = older byte, rd_data[15:8] = newer byte; the first byte written lands in the LSBs.
REQ-020 Read latency SHALL be 1 cycle (normal mode, not show-ahead): data appears on the edge after the accepting rd_req cycle; rd_data holds between reads.
REQ-021 Acceptance SHALL be decided from cnt at the start of the cycle.
REQ-022 Simultaneous accepted write and read: cnt <= cnt + 1 - 2.
REQ-023 Simultaneous write and read at cnt=1: the read is rejected, the write is accepted, cnt becomes 2.
REQ-024 Simultaneous write and read at cnt=256: the write is rejected, the read is accepted, cnt becomes 254.
REQ-025 Status SHALL update on the edge that changes cnt; there is no pipeline lag on flags.
REQ-026 With cnt odd, the trailing byte SHALL remain stored until its partner is written; rd_usedw rounds down.

Reset
REQ-027 On sys_rst=1 at a sys_clk edge: cnt, write pointer and read pointer SHALL be 0, and rd_data SHALL be 16'h0000.
REQ-028 After reset: wr_empty=1, rd_empty=1, wr_full=0, rd_full=0, wr_usedw=0, rd_usedw=0.
REQ-029 Reset SHALL take priority over concurrent wr_req/rd_req, including mid-operation; memory contents need not be cleared.
REQ-030 All flops SHALL be reset synchronously; there SHALL be no asynchronous reset paths.

Structure
REQ-031 Shared package fifo_dcfifo_pkg SHALL hold WR_W, RD_W, WR_DEPTH, derived address widths (8 for bytes, 7 for words) and count width (9).
REQ-032 Storage SHALL be one sub-module, fifo_dcfifo_ram: 256x8 array, 1 write port, 2-byte-wide registered read port (addresses 2k and 2k+1); inferable as block RAM.
REQ-033 Pointer, count and flag logic SHALL reside in fifo_dcfifo.

Verification
REQ-034 Reset then idle -> wr_empty=1, rd_empty=1, both usedw=0, rd_data=0.
REQ-035 Write 0..255 on consecutive cycles -> wr_usedw reaches 256, wr_full=1 and rd_full=1 after the 256th byte, rd_usedw=128; a 257th write is ignored (wr_usedw stays 256).
REQ-036 From full, read 128 consecutive words -> rd_data sequence 16'h0100, 16'h0302, ... 16'hFFFE; rd_empty=1 and wr_empty=1 after the last read; an extra rd_req leaves rd_data=16'hFFFE.
REQ-037 Write a single byte 8'hAA -> wr_usedw=1, rd_usedw=0, rd_empty=1; rd_req ignored; write 8'hBB -> rd_empty=0; read -> rd_data=16'hBBAA.
REQ-038 Pointer wrap: fill to 256, read 64 words, write 128 more bytes, then drain -> data continuous and in order across the 255->0 wrap.
REQ-039 Simultaneous wr_req and rd_req at cnt=10 -> cnt=9; at cnt=256 -> 254 (write dropped); at cnt=1 -> 2 (read dropped); assert sys_rst mid-stream -> all flags return to reset values on the next edge.
